bus_arbiter: RTL and testbench

- Round-robin arbiter for the shared 16-bit processor bus.
- Requesters are the per-core bus masters, or register groups such as accumulators and address registers that drive the bus through their LDBUS enables.
- Issues exactly one registered one-hot grant at a time.
- Inserts one all-idle turnaround cycle between owners so that tri-stated register outputs never overlap.
- Enforces a maximum hold time with a timeout flag.

---
 rtl/bus_arbiter.sv | 126 ++++++++++++
 tb/tb_bus_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bus_arbiter : round-robin one-hot bus arbiter with turnaround and hold
//               timeout. Optional macro BUS_ARB_PRIO0_EN gives requester 0
//               fixed top priority.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int IDW     = 2,
  parameter int MAXHOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2**IDW-1:0]  REQ,
  input  logic [2**IDW-1:0]  DONE,
  output logic [2**IDW-1:0]  GNT,
  output logic [IDW-1:0]     OWNER,
  output logic               BUSY,
  output logic               TIMEOUT
);

  localparam int        N         = 2**IDW;
  localparam logic [7:0] HOLD_LAST = 8'(MAXHOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [7:0]     cnt;

  logic [N-1:0]   cand;
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] idx;
  logic           release_hit;
  logic           timeout_hit;
  logic [IDW-1:0] next_ptr;
`ifdef BUS_ARB_PRIO0_EN
  logic           prio0;
`endif

  always_comb begin
    cand      = REQ;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
`ifdef BUS_ARB_PRIO0_EN
    // Requester 0 sits out the turnaround after its own grant so the others
    // are not starved; it otherwise beats every rotating requester.
    prio0   = cand[0] && !(state == TURN && OWNER == '0);
    cand[0] = 1'b0;
`endif
    // Descending scan: the last hit is the closest to ptr in search order.
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr + IDW'(k);
      if (cand[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
`ifdef BUS_ARB_PRIO0_EN
    if (prio0) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  always_comb begin
    release_hit = DONE[OWNER] || !REQ[OWNER];
    timeout_hit = (MAXHOLD != 0) && (cnt == HOLD_LAST);
    next_ptr    = OWNER + IDW'(1);
`ifdef BUS_ARB_PRIO0_EN
    if (OWNER == '0) next_ptr = ptr;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      GNT     <= '0;
      OWNER   <= '0;
      BUSY    <= 1'b0;
      TIMEOUT <= 1'b0;
    end else begin
      TIMEOUT <= 1'b0;
      case (state)
        IDLE, TURN: begin
          if (win_found) begin
            state <= GRANT;
            GNT   <= {{(N-1){1'b0}}, 1'b1} << win_idx;
            OWNER <= win_idx;
            BUSY  <= 1'b1;
            cnt   <= '0;
          end else begin
            state <= IDLE;
            GNT   <= '0;
            BUSY  <= 1'b0;
          end
        end
        GRANT: begin
          cnt <= cnt + 8'd1;
          if (release_hit || timeout_hit) begin
            state   <= TURN;
            GNT     <= '0;
            ptr     <= next_ptr;
            TIMEOUT <= !release_hit;
          end
        end
        default: begin
          state <= IDLE;
          GNT   <= '0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bus_arbiter : directed plus random checks of bus_arbiter against a
//                  cycle-level behavioural model.
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int MH = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   REQ;
  logic [3:0]   DONE;
  logic [3:0]   GNT;
  logic [1:0]   OWNER;
  logic         BUSY;
  logic         TIMEOUT;

  int tests  = 0;
  int failed = 0;

  // model: granted / in gap / owner / rotation start / cycles held / pulse
  bit m_gnt, m_gap, m_to;
  int m_owner, m_ptr, m_held;

  bus_arbiter #(.IDW(2), .MAXHOLD(MH)) dut (
    .clk(clk), .rst(rst), .REQ(REQ), .DONE(DONE),
    .GNT(GNT), .OWNER(OWNER), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit pick(input logic [3:0] r, output int w);
    w = 0;
`ifdef BUS_ARB_PRIO0_EN
    if (r[0] && !(m_gap && m_owner == 0)) return 1'b1;
    for (int k = 0; k < N; k++)
      if ((m_ptr + k) % N != 0 && r[(m_ptr + k) % N]) begin
        w = (m_ptr + k) % N;
        return 1'b1;
      end
`else
    for (int k = 0; k < N; k++)
      if (r[(m_ptr + k) % N]) begin
        w = (m_ptr + k) % N;
        return 1'b1;
      end
`endif
    return 1'b0;
  endfunction

  task automatic model(input logic [3:0] r, input logic [3:0] d, input logic rs);
    int  w;
    bit  rel;
    if (rs) begin
      m_gnt = 0; m_gap = 0; m_to = 0; m_owner = 0; m_ptr = 0; m_held = 0;
      return;
    end
    m_to = 0;
    if (m_gnt) begin
      m_held++;
      rel = d[m_owner] || !r[m_owner];
      if (rel || (MH != 0 && m_held == MH)) begin
        m_gnt = 0;
        m_gap = 1;
        m_to  = !rel;
`ifdef BUS_ARB_PRIO0_EN
        if (m_owner != 0) m_ptr = (m_owner + 1) % N;
`else
        m_ptr = (m_owner + 1) % N;
`endif
      end
    end else if (pick(r, w)) begin
      m_gnt = 1; m_gap = 0; m_owner = w; m_held = 0;
    end else begin
      m_gap = 0;
    end
  endtask

  task automatic cycle(input logic [3:0] r, input logic [3:0] d, input logic rs);
    REQ = r; DONE = d; rst = rs;
    @(posedge clk);
    model(r, d, rs);
    #1;
    chk("gnt",     32'(GNT),     m_gnt ? 32'(1 << m_owner) : 32'd0);
    chk("owner",   32'(OWNER),   32'(m_owner));
    chk("busy",    32'(BUSY),    32'(m_gnt || m_gap));
    chk("timeout", 32'(TIMEOUT), 32'(m_to));
    chk("onehot",  32'($countones(GNT) <= 1), 32'd1);
  endtask

  initial begin
    int order [5];
    logic [3:0] r;
    logic [3:0] d;
`ifdef BUS_ARB_PRIO0_EN
    order = '{0, 1, 0, 2, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    rst = 1'b1; REQ = '0; DONE = '0;
    m_gnt = 0; m_gap = 0; m_to = 0; m_owner = 0; m_ptr = 0; m_held = 0;

    // reset held with all requests pending
    for (int i = 0; i < 3; i++) cycle(4'b1111, 4'b0000, 1'b1);
    chk("rst_busy", 32'(BUSY), 32'd0);

    // rotation: each owner releases on its second grant cycle
    cycle(4'b1111, 4'b0000, 1'b0);
    chk("first_gnt", 32'(GNT), 32'b0001);
    for (int g = 1; g < 5; g++) begin
      cycle(4'b1111, 4'b0000, 1'b0);
      cycle(4'b1111, 4'(1 << order[g-1]), 1'b0);
      chk("rr_gap", 32'(GNT), 32'd0);
      cycle(4'b1111, 4'b0000, 1'b0);
      chk("rr_order", 32'(GNT), 32'(1 << order[g]));
    end
    cycle(4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0);

    // single requester with explicit DONE
    cycle(4'b0100, 4'b0000, 1'b0);
    chk("single_gnt", 32'(GNT), 32'b0100);
    chk("single_own", 32'(OWNER), 32'd2);
    cycle(4'b0100, 4'b0100, 1'b0);
    chk("single_rel", 32'(GNT), 32'd0);
    cycle(4'b0000, 4'b0000, 1'b0);
    chk("single_idle", 32'(BUSY), 32'd0);

    // hold timeout: 16 grant cycles, one pulse, then re-grant
    cycle(4'b0010, 4'b0000, 1'b0);
    for (int i = 1; i < MH; i++) begin
      cycle(4'b0010, 4'b0000, 1'b0);
      chk("to_hold", 32'(GNT), 32'b0010);
    end
    cycle(4'b0010, 4'b0000, 1'b0);
    chk("to_revoke", 32'(GNT), 32'd0);
    chk("to_pulse", 32'(TIMEOUT), 32'd1);
    cycle(4'b0010, 4'b0000, 1'b0);
    chk("to_regrant", 32'(GNT), 32'b0010);
    chk("to_clear", 32'(TIMEOUT), 32'd0);
    cycle(4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0);

    // non-owner DONE ignored, REQ drop releases, DONE at last hold cycle
    cycle(4'b1000, 4'b0000, 1'b0);
    chk("own3", 32'(GNT), 32'b1000);
    cycle(4'b1000, 4'b0001, 1'b0);
    cycle(4'b1000, 4'b0001, 1'b0);
    chk("ignore_done", 32'(GNT), 32'b1000);
    cycle(4'b0000, 4'b0000, 1'b0);
    chk("req_drop", 32'(GNT), 32'd0);
    chk("req_drop_to", 32'(TIMEOUT), 32'd0);
    cycle(4'b0000, 4'b0000, 1'b0);
    cycle(4'b1000, 4'b0000, 1'b0);
    for (int i = 0; i < MH - 1; i++) cycle(4'b1000, 4'b0000, 1'b0);
    chk("late_hold", 32'(GNT), 32'b1000);
    cycle(4'b1000, 4'b1000, 1'b0);
    chk("late_rel", 32'(GNT), 32'd0);
    chk("late_to", 32'(TIMEOUT), 32'd0);
    cycle(4'b0000, 4'b0000, 1'b0);

    // reset in the middle of a grant
    cycle(4'b0010, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) cycle(4'b0010, 4'b0000, 1'b0);
    cycle(4'b0010, 4'b0000, 1'b1);
    chk("mid_rst_gnt", 32'(GNT), 32'd0);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    cycle(4'b1010, 4'b0000, 1'b0);
    chk("post_rst_gnt", 32'(GNT), 32'b0010);
    cycle(4'b0000, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0);

    // random traffic
    r = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      d = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      cycle(r, d, $urandom_range(0, 79) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
